reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer of the out-of-order core; closes the loop that the rename stage opens. Dispatch allocates one entry per renamed instruction and receives its ROB number. Functional units report results by ROB number. The buffer broadcasts results to rename/RS as wakeups and retires up to two instructions per cycle in program order, returning old physical tags on `freed_tag_1`/`freed_tag_2` and architectural results to the register file.

## Interface
- `DEPTH`, 64, entries; power of two; ROB number width `$clog2(DEPTH)` (6).
- `PREG_W`, 6, physical tag width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `alloc_valid` in 1: dispatch presents an instruction.
- `alloc_ready` out 1: `count < DEPTH`.
- `alloc_has_rd` in 1: instruction writes a register.
- `alloc_arch_rd` in 5: architectural destination.
- `alloc_physical_rd` in PREG_W: new tag.
- `alloc_old_physical_rd` in PREG_W: previous mapping of rd, freed at retire.
- `alloc_rob_num` out 6: tail pointer; number assigned if allocation fires.
- `complete_valid_k` in 1, `complete_rob_num_k` in 6, `complete_value_k` in 32, k=0..2: FU completion ports.
- `wakeup_active` out 1, `wakeup_tag` out PREG_W, `wakeup_value` out 32: result broadcast to rename/RS.
- `freed_tag_1`, `freed_tag_2` out PREG_W: tags returned to the free list; 0 = none.
- `retire_valid_1/2` out 1, `retire_arch_rd_1/2` out 5, `retire_value_1/2` out 32: architectural commit.

## Operation
- Entry fields: valid, done, bcast, has_rd, arch_rd, prd, old_prd, value.
- Reset: all entries invalid; head = tail = count = 0; every output 0 except `alloc_ready` = 1 and `alloc_rob_num` = 0.
- Allocate when `alloc_valid && alloc_ready`: write the entry at tail with done = bcast = 0, then increment tail modulo DEPTH.
- Completion port k: if the target entry is valid and not done, set done and store the value. If `has_rd` = 0, also set bcast.
  - Completion to an invalid or already-done entry: ignored.
  - Two ports naming the same ROB number in one cycle: lowest k wins; the others are dropped.
- Broadcast: each cycle, select the oldest entry (rotated scan from head) with valid, done, !bcast. Register `wakeup_active` = 1 with its prd/value and set its bcast. At most one broadcast per cycle.
- Retire slot 1: head entry valid, done, bcast. Slot 2: head+1 qualifies in the same way **and** slot 1 retires.
- For each retiring slot:
  - Clear valid; advance head by 1 or 2; decrement count accordingly.
  - Register `freed_tag_n` = old_prd if has_rd, else 0.
  - Register `retire_valid_n` = has_rd, with `retire_arch_rd_n` and `retire_value_n`.
- Count update: `count_next = count + alloc - retired`. Width `$clog2(DEPTH)+1`.
- Pointers wrap DEPTH-1 → 0.

## Timing
- `alloc_ready` and `alloc_rob_num` depend only on registered state. At full, no allocation is accepted even in a cycle where retirement frees space; `alloc_ready` rises the cycle after the first retire.
- Completion sampled at edge N. The earliest wakeup is registered at N+1 and visible during cycle N+1..N+2.
- Earliest retire for that entry: edge N+2. `freed_tag`/`retire_*` are visible for one cycle only and are 0 otherwise.
- No-rd entry completed at N: retirable at N+1.
- Allocate at N, complete at N+1 (earliest): done is set at edge N+1.
- Completion arriving in the same cycle an entry is scanned: the entry becomes eligible next cycle, with no bypass.
- Empty buffer: no wakeup, no retire; outputs stay 0.
- `reset` asserted mid-operation: immediately returns to the reset state. In-flight entries are discarded and no tags are freed.

## Structure
- Shared package `rob_pkg`:
  - entry struct;
  - `ROB_DEPTH`, `ROB_IDX_W`, `PREG_W`;
  - `NO_TAG = 0`.
- One sub-module, `rob_oldest_select`: rotated priority picker. Inputs are a DEPTH-bit eligibility vector and head; outputs are found and index.
- The top instantiates the selector for broadcast only; retirement checks head and head+1 directly.

## Test plan
- Reset: drive `reset` = 0 mid-run → all outputs 0, `alloc_ready` = 1, `alloc_rob_num` = 0. Release, allocate one → `alloc_rob_num` = 1.
- Allocate rd = x5 with prd = 33, old = 12. Complete port 0, value 0x1234 → `wakeup` tag 33 value 0x1234 one cycle later; next cycle `freed_tag_1` = 12, `retire_arch_rd_1` = 5, `retire_value_1` = 0x1234.
- Allocate A, B. Complete B first → B broadcast but not retired. Complete A → A broadcast, then A and B retire in the same cycle on slots 1 and 2.
- Fill 64 entries → `alloc_ready` = 0 and extra `alloc_valid` is ignored. Retire one → `alloc_ready` = 1 next cycle. Allocation wraps to ROB number 0.
- Same cycle, ports 0/1/2 complete entries 3/1/2 → wakeups issue in order 1, 2, 3 on consecutive cycles.
- Store (`has_rd` = 0) completes → no wakeup; retires next cycle with `freed_tag_1` = 0 and `retire_valid_1` = 0. Duplicate completion to an already-done entry → no change.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// rob_pkg: shared types and constants for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH = 64;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = ROB_IDX_W + 1;
    localparam int PREG_W = 6;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [PREG_W-1:0] preg_t;

    localparam preg_t NO_TAG = '0;

    typedef struct packed {
        logic valid;
        logic done;
        logic bcast;
        logic has_rd;
        logic [4:0] arch_rd;
        preg_t prd;
        preg_t old_prd;
        logic [31:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic active;
        preg_t tag;
        logic [31:0] value;
    } wakeup_t;

    typedef struct packed {
        logic valid;
        logic [4:0] arch_rd;
        logic [31:0] value;
        preg_t freed;
    } retire_t;

    // Entries without a destination retire silently: no commit, no freed tag.
    function automatic retire_t retire_info(rob_entry_t e, logic fire);
        return (fire && e.has_rd) ? retire_t'{1'b1, e.arch_rd, e.value, e.old_prd}
                                  : retire_t'{1'b0, 5'd0, 32'd0, NO_TAG};
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, completion, wakeup and retire signals of the reorder buffer
interface reorder_buffer_if;
    import rob_pkg::*;
    logic alloc_valid;
    logic alloc_ready;
    logic alloc_has_rd;
    logic [4:0] alloc_arch_rd;
    preg_t alloc_physical_rd;
    preg_t alloc_old_physical_rd;
    rob_idx_t alloc_rob_num;
    logic [2:0] complete_valid;
    rob_idx_t [2:0] complete_rob_num;
    logic [2:0][31:0] complete_value;
    logic wakeup_active;
    preg_t wakeup_tag;
    logic [31:0] wakeup_value;
    preg_t freed_tag_1, freed_tag_2;
    logic retire_valid_1, retire_valid_2;
    logic [4:0] retire_arch_rd_1, retire_arch_rd_2;
    logic [31:0] retire_value_1, retire_value_2;

    modport master (
        output alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_physical_rd, alloc_old_physical_rd,
        output complete_valid, complete_rob_num, complete_value,
        input alloc_ready, alloc_rob_num, wakeup_active, wakeup_tag, wakeup_value,
        input freed_tag_1, freed_tag_2, retire_valid_1, retire_valid_2,
        input retire_arch_rd_1, retire_arch_rd_2, retire_value_1, retire_value_2
    );

    modport slave (
        input alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_physical_rd, alloc_old_physical_rd,
        input complete_valid, complete_rob_num, complete_value,
        output alloc_ready, alloc_rob_num, wakeup_active, wakeup_tag, wakeup_value,
        output freed_tag_1, freed_tag_2, retire_valid_1, retire_valid_2,
        output retire_arch_rd_1, retire_arch_rd_2, retire_value_1, retire_value_2
    );
endinterface

// File: rtl/reorder_buffer_oldest_select.sv
// rob_oldest_select: first eligible entry scanning upward from head with wrap-around
module rob_oldest_select
    import rob_pkg::*;
(
    input  logic [ROB_DEPTH-1:0] elig_i,
    input  rob_idx_t             head_i,
    output logic                 found_o,
    output rob_idx_t             idx_o
);
    rob_idx_t j;

    // Scanning youngest-to-oldest lets the oldest hit overwrite the rest.
    always_comb begin
        found_o = 1'b0;
        idx_o = '0;
        j = '0;
        for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
            j = head_i + rob_idx_t'(i);
            if (elig_i[j]) begin
                found_o = 1'b1;
                idx_o = j;
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with result wakeup and dual-slot retire
module reorder_buffer
    import rob_pkg::*;
(
    input logic clk,
    input logic reset,
    reorder_buffer_if.slave bus
);
    rob_entry_t ent_q [ROB_DEPTH];
    rob_entry_t ent_d [ROB_DEPTH];
    rob_idx_t head_q, head_d, tail_q, tail_d, head1, bc_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ROB_DEPTH-1:0] elig;
    logic bc_found, ret1, ret2, alloc;
    wakeup_t wake_q, wake_d;
    retire_t slot1_q, slot1_d, slot2_q, slot2_d;

    rob_oldest_select u_sel (.elig_i(elig), .head_i(head_q), .found_o(bc_found), .idx_o(bc_idx));

    assign head1 = head_q + rob_idx_t'(1);
    assign bus.alloc_ready = !count_q[ROB_IDX_W];
    assign bus.alloc_rob_num = tail_q;
    assign alloc = bus.alloc_valid && bus.alloc_ready;
    assign ret1 = ent_q[head_q].valid && ent_q[head_q].done && ent_q[head_q].bcast;
    assign ret2 = ret1 && ent_q[head1].valid && ent_q[head1].done && ent_q[head1].bcast;

    assign bus.wakeup_active = wake_q.active;
    assign bus.wakeup_tag = wake_q.tag;
    assign bus.wakeup_value = wake_q.value;
    assign bus.freed_tag_1 = slot1_q.freed;
    assign bus.freed_tag_2 = slot2_q.freed;
    assign bus.retire_valid_1 = slot1_q.valid;
    assign bus.retire_valid_2 = slot2_q.valid;
    assign bus.retire_arch_rd_1 = slot1_q.arch_rd;
    assign bus.retire_arch_rd_2 = slot2_q.arch_rd;
    assign bus.retire_value_1 = slot1_q.value;
    assign bus.retire_value_2 = slot2_q.value;

    always_comb begin
        elig = '0;
        for (int i = 0; i < ROB_DEPTH; i++)
            elig[i] = ent_q[i].valid && ent_q[i].done && !ent_q[i].bcast;
    end

    always_comb begin
        ent_d = ent_q;
        // Checking against ent_d lets the lowest port win a same-cycle collision.
        for (int k = 0; k < 3; k++) begin
            if (bus.complete_valid[k] && ent_d[bus.complete_rob_num[k]].valid
                && !ent_d[bus.complete_rob_num[k]].done) begin
                ent_d[bus.complete_rob_num[k]].done = 1'b1;
                ent_d[bus.complete_rob_num[k]].value = bus.complete_value[k];
                ent_d[bus.complete_rob_num[k]].bcast = !ent_d[bus.complete_rob_num[k]].has_rd;
            end
        end
        if (bc_found) ent_d[bc_idx].bcast = 1'b1;
        if (ret1) ent_d[head_q].valid = 1'b0;
        if (ret2) ent_d[head1].valid = 1'b0;
        if (alloc)
            ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, bcast: 1'b0, has_rd: bus.alloc_has_rd,
                              arch_rd: bus.alloc_arch_rd, prd: bus.alloc_physical_rd,
                              old_prd: bus.alloc_old_physical_rd, value: '0};
        head_d = head_q + rob_idx_t'(ret1) + rob_idx_t'(ret2);
        tail_d = tail_q + rob_idx_t'(alloc);
        count_d = count_q + CNT_W'(alloc) - CNT_W'(ret1) - CNT_W'(ret2);
        wake_d = bc_found ? wakeup_t'{1'b1, ent_q[bc_idx].prd, ent_q[bc_idx].value} : wakeup_t'('0);
        slot1_d = retire_info(ent_q[head_q], ret1);
        slot2_d = retire_info(ent_q[head1], ret2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            wake_q <= '0;
            slot1_q <= '0;
            slot2_q <= '0;
        end else begin
            ent_q <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            wake_q <= wake_d;
            slot1_q <= slot1_d;
            slot2_q <= slot2_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checks of reorder_buffer against a program-order queue model
module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if bus ();
    reorder_buffer dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int rob;
        bit has_rd;
        int rd;
        int prd;
        int old;
        longint value;
        bit done;
        bit bc;
    } ment_t;

    ment_t q[$];
    int tail;
    bit e_wa;
    int e_wt;
    longint e_wv;
    bit e_rv [2];
    int e_rd [2];
    longint e_val [2];
    int e_ft [2];
    int checks = 0;
    int fails = 0;
    int num;

    task automatic chk(string n, longint a, longint e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        tail = 0;
        e_wa = 0;
        e_wt = 0;
        e_wv = 0;
        for (int s = 0; s < 2; s++) begin
            e_rv[s] = 0;
            e_rd[s] = 0;
            e_val[s] = 0;
            e_ft[s] = 0;
        end
    endfunction

    // One clock edge of program-order behaviour: outputs come from the state before the edge.
    function automatic void model_step();
        int w = -1;
        int sz = q.size();
        bit fire [2];
        for (int i = 0; i < sz; i++)
            if (w < 0 && q[i].done && !q[i].bc) w = i;
        fire[0] = sz > 0 && q[0].done && q[0].bc;
        fire[1] = fire[0] && sz > 1 && q[1].done && q[1].bc;
        e_wa = w >= 0;
        e_wt = 0;
        e_wv = 0;
        if (w >= 0) begin
            e_wt = q[w].prd;
            e_wv = q[w].value;
        end
        for (int s = 0; s < 2; s++) begin
            e_rv[s] = 0;
            e_rd[s] = 0;
            e_val[s] = 0;
            e_ft[s] = 0;
            if (fire[s] && q[s].has_rd) begin
                e_rv[s] = 1;
                e_rd[s] = q[s].rd;
                e_val[s] = q[s].value;
                e_ft[s] = q[s].old;
            end
        end
        for (int k = 0; k < 3; k++)
            if (bus.complete_valid[k])
                for (int i = 0; i < sz; i++)
                    if (q[i].rob == int'(bus.complete_rob_num[k]) && !q[i].done) begin
                        q[i].done = 1;
                        q[i].value = longint'(bus.complete_value[k]);
                        if (!q[i].has_rd) q[i].bc = 1;
                    end
        if (w >= 0) q[w].bc = 1;
        if (fire[1]) void'(q.pop_front());
        if (fire[0]) void'(q.pop_front());
        if (bus.alloc_valid && sz < ROB_DEPTH) begin
            q.push_back('{rob: tail, has_rd: bus.alloc_has_rd, rd: int'(bus.alloc_arch_rd),
                          prd: int'(bus.alloc_physical_rd), old: int'(bus.alloc_old_physical_rd),
                          value: 0, done: 0, bc: 0});
            tail = (tail + 1) % ROB_DEPTH;
        end
    endfunction

    task automatic check_all();
        chk("alloc_ready", bus.alloc_ready, q.size() < ROB_DEPTH);
        chk("alloc_rob_num", bus.alloc_rob_num, tail);
        chk("wakeup_active", bus.wakeup_active, e_wa);
        chk("wakeup_tag", bus.wakeup_tag, e_wt);
        chk("wakeup_value", bus.wakeup_value, e_wv);
        chk("retire_valid_1", bus.retire_valid_1, e_rv[0]);
        chk("retire_valid_2", bus.retire_valid_2, e_rv[1]);
        chk("retire_arch_rd_1", bus.retire_arch_rd_1, e_rd[0]);
        chk("retire_arch_rd_2", bus.retire_arch_rd_2, e_rd[1]);
        chk("retire_value_1", bus.retire_value_1, e_val[0]);
        chk("retire_value_2", bus.retire_value_2, e_val[1]);
        chk("freed_tag_1", bus.freed_tag_1, e_ft[0]);
        chk("freed_tag_2", bus.freed_tag_2, e_ft[1]);
    endtask

    task automatic idle_inputs();
        bus.alloc_valid = 0;
        bus.alloc_has_rd = 0;
        bus.alloc_arch_rd = '0;
        bus.alloc_physical_rd = '0;
        bus.alloc_old_physical_rd = '0;
        bus.complete_valid = '0;
        bus.complete_rob_num = '0;
        bus.complete_value = '0;
    endtask

    task automatic set_alloc(bit hr, int rd, int prd, int old);
        bus.alloc_valid = 1;
        bus.alloc_has_rd = hr;
        bus.alloc_arch_rd = 5'(rd);
        bus.alloc_physical_rd = preg_t'(prd);
        bus.alloc_old_physical_rd = preg_t'(old);
    endtask

    task automatic set_comp(int k, int n, int unsigned v);
        bus.complete_valid[k] = 1;
        bus.complete_rob_num[k] = rob_idx_t'(n);
        bus.complete_value[k] = v;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2 reset = 1'b0;
        #1;
        check_all();
        chk("por_ready", bus.alloc_ready, 1);
        chk("por_rob_num", bus.alloc_rob_num, 0);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // single rd instruction: wakeup then retire
        set_alloc(1, 5, 33, 12); step();
        set_comp(0, 0, 32'h1234); step();
        step();
        chk("wake_active", bus.wakeup_active, 1);
        chk("wake_tag", bus.wakeup_tag, 33);
        chk("wake_value", bus.wakeup_value, 'h1234);
        step();
        chk("ret1_valid", bus.retire_valid_1, 1);
        chk("ret1_freed", bus.freed_tag_1, 12);
        chk("ret1_rd", bus.retire_arch_rd_1, 5);
        chk("ret1_value", bus.retire_value_1, 'h1234);

        // out-of-order completion, paired retire
        set_alloc(1, 7, 40, 20); step();
        set_alloc(1, 8, 41, 21); step();
        set_comp(0, 2, 32'hB); step();
        step();
        chk("b_wake_tag", bus.wakeup_tag, 41);
        step();
        chk("b_not_retired", bus.retire_valid_1, 0);
        set_comp(1, 1, 32'hA); step();
        step();
        chk("a_wake_tag", bus.wakeup_tag, 40);
        step();
        chk("pair_valid_1", bus.retire_valid_1, 1);
        chk("pair_rd_1", bus.retire_arch_rd_1, 7);
        chk("pair_valid_2", bus.retire_valid_2, 1);
        chk("pair_rd_2", bus.retire_arch_rd_2, 8);
        chk("pair_freed_2", bus.freed_tag_2, 21);

        // store: no wakeup, silent retire next cycle
        set_alloc(0, 0, 0, 0); step();
        set_comp(2, 3, 32'hDEAD); step();
        step();
        chk("st_no_wake", bus.wakeup_active, 0);
        chk("st_ret_valid", bus.retire_valid_1, 0);
        chk("st_freed", bus.freed_tag_1, 0);

        // duplicate completion to a done entry is ignored
        set_alloc(1, 9, 50, 30); step();
        set_alloc(1, 10, 51, 31); step();
        set_comp(0, 5, 32'hAA); step();
        set_comp(0, 5, 32'hBB); set_comp(1, 5, 32'hCC); step();
        chk("dup_wake_value", bus.wakeup_value, 'hAA);
        set_comp(0, 4, 32'hC0); step();
        step();
        step();
        chk("dup_ret_value_2", bus.retire_value_2, 'hAA);
        chk("dup_ret_rd_2", bus.retire_arch_rd_2, 10);

        // asynchronous reset with entries in flight
        set_alloc(1, 11, 52, 32); step();
        set_alloc(1, 12, 53, 33); step();
        set_comp(0, 6, 32'h66); step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("mr_ready", bus.alloc_ready, 1);
        chk("mr_rob_num", bus.alloc_rob_num, 0);
        @(posedge clk);
        #1;
        check_all();
        chk("mr_no_wake", bus.wakeup_active, 0);
        chk("mr_no_free", bus.freed_tag_1, 0);
        reset = 1'b1;
        set_alloc(1, 1, 1, 2); step();
        chk("mr_rob_num_after", bus.alloc_rob_num, 1);

        // same-cycle completions wake up oldest first
        for (int i = 1; i <= 3; i++) begin
            set_alloc(1, 12 + i, 40 + i, i);
            step();
        end
        set_comp(0, 3, 32'h303); set_comp(1, 1, 32'h101); set_comp(2, 2, 32'h202); step();
        step();
        chk("order_1", bus.wakeup_tag, 41);
        step();
        chk("order_2", bus.wakeup_tag, 42);
        step();
        chk("order_3", bus.wakeup_tag, 43);
        set_comp(0, 0, 32'h100);
        steps(5);

        // fill to full, wrap, overflow attempt, retire then refill
        for (int i = 0; i < ROB_DEPTH; i++) begin
            set_alloc(1, i % 32, i % 64, (i + 7) % 64);
            step();
            if (i == 59) chk("wrap_rob_num", bus.alloc_rob_num, 0);
        end
        chk("full_ready", bus.alloc_ready, 0);
        chk("full_rob_num", bus.alloc_rob_num, 4);
        set_alloc(1, 1, 1, 1); step();
        chk("full_ignored", bus.alloc_rob_num, 4);
        set_alloc(1, 1, 1, 1); set_comp(0, 4, 32'h44); step();
        set_alloc(1, 1, 1, 1); step();
        set_alloc(1, 1, 1, 1); step();
        chk("ready_after_retire", bus.alloc_ready, 1);
        chk("no_alloc_at_full", bus.alloc_rob_num, 4);
        set_alloc(1, 1, 1, 1); step();
        chk("refill_rob_num", bus.alloc_rob_num, 5);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 55)
                set_alloc($urandom_range(0, 9) < 8, $urandom_range(0, 31), $urandom_range(0, 63),
                          $urandom_range(0, 63));
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 99) < 45) begin
                    num = $urandom_range(0, 63);
                    if (q.size() > 0 && $urandom_range(0, 9) < 9)
                        num = q[$urandom_range(0, q.size() - 1)].rob;
                    set_comp(k, num, $urandom);
                end
            end
            step();
        end
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
